// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Hazard unit for the 5-stage MIPS pipeline. It tracks its own shadow copy
// of the in-flight instructions in EX, MEM and WB and generates stall, flush
// and forwarding controls for the datapath. Two saturating performance
// counters record stall cycles and branch-flush cycles.
//
// Ports:
//   CLK        core clock, rising edge
//   RST        asynchronous active-low reset
//   RsD, RtD   source registers of the instruction in ID
//   WriteRegD  destination register of the instruction in ID (after RegDst)
//   RegWriteD  ID instruction writes the register file
//   MemtoRegD  ID instruction is a load
//   JumpD      ID instruction is a jump
//   PCSrcE     branch taken, resolved in EX
//   CntClr     synchronous clear of both performance counters
//   StallF     hold PC
//   StallD     hold the IF/ID register
//   FlushD     clear the IF/ID register
//   FlushE     clear the ID/EX register (insert a bubble)
//   ForwardAE  EX operand A select: 00 regfile, 10 MEM ALU result, 01 WB result
//   ForwardBE  EX operand B select, same encoding
//   StallCnt   saturating count of cycles with StallD=1
//   FlushCnt   saturating count of branch-caused FlushE cycles
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [REG_AW-1:0] RsD,
    input  logic [REG_AW-1:0] RtD,
    input  logic [REG_AW-1:0] WriteRegD,
    input  logic              RegWriteD,
    input  logic              MemtoRegD,
    input  logic              JumpD,
    input  logic              PCSrcE,
    input  logic              CntClr,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt
);

    // Writer view of a pipeline slot: all that MEM and WB need to drive
    // forwarding decisions.
    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic [REG_AW-1:0] write_reg;
    } writer_t;

    // Full EX slot: writer view plus the load flag (for load-use) and the
    // source registers (for forwarding selection).
    typedef struct packed {
        writer_t           wr;
        logic              mem_to_reg;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
    } entry_t;

    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    entry_t             e_r;
    writer_t            m_r;
    writer_t            w_r;
    logic               active_r;
    logic [CNT_W-1:0]   stall_cnt_r;
    logic [CNT_W-1:0]   flush_cnt_r;

    entry_t             d_entry_s;
    logic               live_s;
    logic               load_use_s;
    logic               branch_s;
    logic               stall_s;
    logic               jump_flush_s;
    logic               flush_d_s;
    logic               flush_e_s;
    logic [1:0]         fwd_a_s;
    logic [1:0]         fwd_b_s;

    // True when slot w will write register r. $0 is hard-wired, so a write
    // to it never produces a dependency.
    function automatic logic writer_match(input writer_t w,
                                          input logic [REG_AW-1:0] r);
        return w.valid & w.reg_write & (w.write_reg != REG_ZERO) &
               (w.write_reg == r);
    endfunction

    // Forwarding select for one EX source register; MEM is the younger
    // producer and therefore wins over WB.
    function automatic logic [1:0] fwd_select(input logic ex_valid,
                                              input logic [REG_AW-1:0] src,
                                              input writer_t mem_w,
                                              input writer_t wb_w);
        logic [1:0] sel;
        if (!ex_valid) begin
            sel = FWD_REG;
        end else if (writer_match(mem_w, src)) begin
            sel = FWD_MEM;
        end else if (writer_match(wb_w, src)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_REG;
        end
        return sel;
    endfunction

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] n;
        if (v == CNT_MAX) begin
            n = v;
        end else begin
            n = v + CNT_ONE;
        end
        return n;
    endfunction

    // Hazard detection and forwarding selection from the registered shadow
    // state and the current ID/EX inputs.
    always_comb begin
        d_entry_s.wr.valid     = 1'b1;
        d_entry_s.wr.reg_write = RegWriteD;
        d_entry_s.wr.write_reg = WriteRegD;
        d_entry_s.mem_to_reg   = MemtoRegD;
        d_entry_s.rs           = RsD;
        d_entry_s.rt           = RtD;

        // Outputs are held low while in reset and on the first cycle after
        // release, so nothing sampled during reset can leak a flush or stall.
        live_s = RST & active_r;

        load_use_s = e_r.wr.valid & e_r.mem_to_reg &
                     (writer_match(e_r.wr, RsD) | writer_match(e_r.wr, RtD));

        // A taken branch squashes the ID instruction, so any load-use seen
        // against it is on the wrong path and must not stall.
        branch_s = live_s & PCSrcE;
        stall_s  = live_s & load_use_s & ~PCSrcE;

        // A stalled jump is re-presented next cycle; flush IF only then.
        jump_flush_s = live_s & JumpD & ~load_use_s & ~PCSrcE;

        flush_d_s = branch_s | jump_flush_s;
        flush_e_s = branch_s | stall_s;

        fwd_a_s = fwd_select(e_r.wr.valid, e_r.rs, m_r, w_r) & {2{RST}};
        fwd_b_s = fwd_select(e_r.wr.valid, e_r.rt, m_r, w_r) & {2{RST}};
    end

    // Shadow pipeline: one stage per clock; stalls bubble EX but MEM/WB drain.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            e_r      <= '0;
            m_r      <= '0;
            w_r      <= '0;
            active_r <= 1'b0;
        end else begin
            active_r <= 1'b1;
            w_r      <= m_r;
            m_r      <= e_r.wr;
            if (flush_e_s) begin
                e_r <= '0;
            end else begin
                e_r <= d_entry_s;
            end
        end
    end

    // Stall-cycle counter; a clear overrides a simultaneous increment.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stall_cnt_r <= CNT_ZERO;
        end else if (CntClr) begin
            stall_cnt_r <= CNT_ZERO;
        end else if (stall_s) begin
            stall_cnt_r <= sat_inc(stall_cnt_r);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Branch-flush counter; a clear overrides a simultaneous increment.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            flush_cnt_r <= CNT_ZERO;
        end else if (CntClr) begin
            flush_cnt_r <= CNT_ZERO;
        end else if (branch_s) begin
            flush_cnt_r <= sat_inc(flush_cnt_r);
        end else begin
            flush_cnt_r <= flush_cnt_r;
        end
    end

    assign StallF    = stall_s;
    assign StallD    = stall_s;
    assign FlushD    = flush_d_s;
    assign FlushE    = flush_e_s;
    assign ForwardAE = fwd_a_s;
    assign ForwardBE = fwd_b_s;
    assign StallCnt  = stall_cnt_r;
    assign FlushCnt  = flush_cnt_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Directed bench for hazard_scoreboard (built with CNT_W=4). Each step drives
// the ID/EX inputs, pushes the outputs expected for that cycle onto a queue,
// and pops/compares them on the following falling edge.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

    logic       clk;
    logic       rst;
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic [4:0] wr_d;
    logic       regw_d;
    logic       memr_d;
    logic       jump_d;
    logic       pcsrc_e;
    logic       cnt_clr;
    logic       stall_f;
    logic       stall_d;
    logic       flush_d;
    logic       flush_e;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic [3:0] stall_cnt;
    logic [3:0] flush_cnt;

    hazard_scoreboard #(.REG_AW(5), .CNT_W(4)) dut (
        .CLK       (clk),
        .RST       (rst),
        .RsD       (rs_d),
        .RtD       (rt_d),
        .WriteRegD (wr_d),
        .RegWriteD (regw_d),
        .MemtoRegD (memr_d),
        .JumpD     (jump_d),
        .PCSrcE    (pcsrc_e),
        .CntClr    (cnt_clr),
        .StallF    (stall_f),
        .StallD    (stall_d),
        .FlushD    (flush_d),
        .FlushE    (flush_e),
        .ForwardAE (fwd_a),
        .ForwardBE (fwd_b),
        .StallCnt  (stall_cnt),
        .FlushCnt  (flush_cnt)
    );

    typedef struct {
        string      tag;
        logic       sf;
        logic       sd;
        logic       fd;
        logic       fe;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [3:0] sc;
        logic [3:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        tests_run++;
        assert (obs === exp_v) else begin
            tests_failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input string tag, input logic sf, input logic sd,
                        input logic fd, input logic fe, input logic [1:0] fa,
                        input logic [1:0] fb, input int sc, input int fc);
        exp_t e;
        e.tag = tag; e.sf = sf; e.sd = sd; e.fd = fd; e.fe = fe;
        e.fa = fa; e.fb = fb; e.sc = 4'(sc); e.fc = 4'(fc);
        exp_q.push_back(e);
    endtask

    task automatic check_now();
        exp_t e;
        if (exp_q.size() == 0) begin
            cmp("queue_empty", 16'd0, 16'd1);
        end else begin
            e = exp_q.pop_front();
            cmp({e.tag, ".StallF"},    16'(stall_f),   16'(e.sf));
            cmp({e.tag, ".StallD"},    16'(stall_d),   16'(e.sd));
            cmp({e.tag, ".FlushD"},    16'(flush_d),   16'(e.fd));
            cmp({e.tag, ".FlushE"},    16'(flush_e),   16'(e.fe));
            cmp({e.tag, ".ForwardAE"}, 16'(fwd_a),     16'(e.fa));
            cmp({e.tag, ".ForwardBE"}, 16'(fwd_b),     16'(e.fb));
            cmp({e.tag, ".StallCnt"},  16'(stall_cnt), 16'(e.sc));
            cmp({e.tag, ".FlushCnt"},  16'(flush_cnt), 16'(e.fc));
        end
    endtask

    task automatic ins(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
                       input logic rw, input logic mr, input logic jmp,
                       input logic pcs, input logic clr);
        rs_d = rs; rt_d = rt; wr_d = wr; regw_d = rw; memr_d = mr;
        jump_d = jmp; pcsrc_e = pcs; cnt_clr = clr;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_now();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        ins(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Reset held with random inputs: everything reads zero.
        for (int i = 0; i < 3; i++) begin
            ins(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom));
            push("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 0, 0);
            cycle();
        end

        // First cycle after release: jump/branch inputs are ignored.
        rst = 1'b1;
        ins(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        push("rel_first", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 0, 0);
        cycle();
        for (int i = 0; i < 2; i++) begin
            ins(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            push("idle", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 0, 0);
            cycle();
        end

        // Load-use: lw $8 then add $9,$8,$0.
        ins(5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push("lw8", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 0, 0);
        cycle();
        ins(5'd8, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("lu_stall", 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 0, 0);
        cycle();
        push("lu_held", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1, 0);
        cycle();
        ins(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("lu_fwd_wb", 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1, 0);
        cycle();

        // Forwarding: add $3 -> sub reads $3,$3 back to back (MEM path).
        ins(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("add3", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1, 0);
        cycle();
        ins(5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("sub", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1, 0);
        cycle();
        // add $6 -> independent -> reader of $6,$6 (WB path).
        ins(5'd1, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("fwd_mem", 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 1, 0);
        cycle();
        ins(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("add6", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1, 0);
        cycle();
        ins(5'd6, 5'd6, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("indep", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1, 0);
        cycle();
        // Writer of $0 then a reader of $0: never forwarded.
        ins(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("fwd_wb", 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1, 0);
        cycle();
        ins(5'd0, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("w0", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1, 0);
        cycle();
        ins(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("fwd_r0", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1, 0);
        cycle();

        // Priority: two writers of $5, then reader of $5 -> MEM wins.
        ins(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("w5a", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1, 0);
        cycle();
        push("w5b", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1, 0);
        cycle();
        ins(5'd5, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("r5", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1, 0);
        cycle();
        ins(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("prio", 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1, 0);
        cycle();

        // Branch taken while a load-use (on rt) is present.
        ins(5'd0, 5'd0, 5'd13, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push("lw13", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1, 0);
        cycle();
        ins(5'd0, 5'd13, 5'd14, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        push("br_over_lu", 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1, 0);
        cycle();
        ins(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("br_after", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1, 1);
        cycle();

        // Plain jump: FlushD only, for one cycle.
        ins(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push("jump", 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1, 1);
        cycle();
        ins(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("jump_after", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1, 1);
        cycle();

        // Jump under load-use: held, then flushes on the replay.
        ins(5'd0, 5'd0, 5'd15, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push("lw15", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1, 1);
        cycle();
        ins(5'd15, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push("jmp_lu", 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1, 1);
        cycle();
        push("jmp_replay", 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2, 1);
        cycle();
        ins(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("jmp_fwd", 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2, 1);
        cycle();

        // Saturation: lw $8,($8) repeatedly gives a stall every other cycle.
        ins(5'd8, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push("sat_start", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2, 1);
        cycle();
        for (int k = 0; k < 22; k++) begin
            push("sat_stall", 1'b1, 1'b1, 1'b0, 1'b1, (k == 0) ? 2'b00 : 2'b01, 2'b00,
                 sat15(2 + k), 1);
            cycle();
            push("sat_bubble", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, sat15(3 + k), 1);
            cycle();
        end

        // Clear together with a stall: both counters read 0 next cycle.
        ins(5'd8, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        push("clr_stall", 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 15, 1);
        cycle();
        ins(5'd8, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push("clr_after", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 0, 0);
        cycle();
        ins(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("post_clr", 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 0, 0);
        cycle();

        // Reset in the middle of a branch flush with a nonzero counter.
        ins(5'd0, 5'd0, 5'd20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push("lw20", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 0, 0);
        cycle();
        ins(5'd20, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("rst_pre_stall", 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 0, 0);
        cycle();
        ins(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        push("rst_pre_br", 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1, 0);
        @(negedge clk);
        check_now();
        #2;
        rst = 1'b0;
        #1;
        push("rst_async", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 0, 0);
        check_now();
        @(posedge clk);
        #1;
        rst = 1'b1;
        push("rel2_first", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 0, 0);
        cycle();
        ins(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("rel2_idle", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 0, 0);
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
